// File: rtl/nk_board_game_ctrl.sv
// N x N, K-in-a-row two-side board game controller: move handshake, legality check, sequential win/draw scan.
// Optional per-move forfeit timer is compiled in with `define GAME_TIMEOUT_EN.
module nk_board_game_ctrl #(
  parameter int N              = 3,
  parameter int K              = 3,
  parameter int POS_W          = 6,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 move_valid,
  output logic                 move_ready,
  input  logic                 move_side,
  input  logic [POS_W-1:0]     move_pos,
  output logic [2*N*N-1:0]     board,
  output logic                 turn,
  output logic                 illegal_move,
  output logic [1:0]           winner,
  output logic                 draw,
  output logic                 game_over,
  output logic                 timeout
);

  localparam int CELLS = N * N;
  localparam int BW    = 2 * CELLS;
  localparam int PAD_W = 2 * (2 ** POS_W);
  localparam logic signed [4:0] NS = 5'(N);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q;
  logic [BW-1:0]     board_q;
  logic [PAD_W-1:0]  board_pad;
  logic              turn_q, illegal_q, draw_q;
  logic [1:0]        winner_q;
  logic              side_q;
  logic signed [4:0] row_q, col_q;
  logic [6:0]        occ_q;
  logic [2:0]        dist_q;
  logic              back_q;
  logic [1:0]        dir_q;
  logic [3:0]        run_q;
  logic              alive_q, hit_q;

  logic              xfer, legal, tmo_hit;
  logic [1:0]        tgt_cell, mark_in, mark, step_cell;
  logic signed [4:0] off, tr, tc;
  logic              inb, step_ok, last_side, hit_dir;
  logic [POS_W-1:0]  step_idx;
  logic [3:0]        run_nx;

  function automatic logic [1:0] mark_of(input logic side);
    return side ? 2'b10 : 2'b01;
  endfunction

  // Move acceptance: cells beyond the board read as empty through the padded view
  always_comb begin
    board_pad = PAD_W'(board_q);
    tgt_cell  = board_pad[{move_pos, 1'b0} +: 2];
    mark_in   = mark_of(move_side);
    xfer      = move_valid && move_ready;
    legal     = (int'(move_pos) < CELLS) && (tgt_cell == 2'b00) && (move_side == turn_q);
  end

  // Scan step: cell at distance dist_q from the latched move, forward or backward along dir_q
  always_comb begin
    mark = mark_of(side_q);
    off  = back_q ? -$signed({2'b00, dist_q}) : $signed({2'b00, dist_q});
    tr   = row_q;
    tc   = col_q;
    case (dir_q)
      2'd0:    tc = col_q + off;
      2'd1:    tr = row_q + off;
      2'd2:    begin tr = row_q + off; tc = col_q + off; end
      default: begin tr = row_q + off; tc = col_q - off; end
    endcase
    inb       = (tr >= 0) && (tr < NS) && (tc >= 0) && (tc < NS);
    step_idx  = POS_W'(int'(tr[2:0]) * N + int'(tc[2:0]));
    step_cell = board_pad[{step_idx, 1'b0} +: 2];
    step_ok   = alive_q && inb && (step_cell == mark);
    run_nx    = run_q + 4'(step_ok);
    last_side = (dist_q == 3'(K - 1));
    hit_dir   = (run_nx >= 4'(K));
  end

`ifdef GAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          timeout_q;

  assign tmo_hit = (state_q == S_WAIT) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES));

  // Illegal attempts keep the clock running; only a legal move restarts it
  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q != S_WAIT || (xfer && legal)) tmo_cnt_q <= '0;
      else if (!tmo_hit)                         tmo_cnt_q <= tmo_cnt_q + TW'(1);
      if ((state_q == S_IDLE || state_q == S_DONE) && start) timeout_q <= 1'b0;
      else if (tmo_hit)                                      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  assign move_ready = (state_q == S_WAIT) && !tmo_hit;

  always_ff @(posedge clock) begin
    illegal_q <= 1'b0;
    if (reset) begin
      state_q  <= S_IDLE;
      board_q  <= '0;
      turn_q   <= 1'b0;
      winner_q <= 2'b00;
      draw_q   <= 1'b0;
      side_q   <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      occ_q    <= '0;
      dist_q   <= '0;
      back_q   <= 1'b0;
      dir_q    <= '0;
      run_q    <= '0;
      alive_q  <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start) begin
          state_q  <= S_WAIT;
          board_q  <= '0;
          winner_q <= 2'b00;
          draw_q   <= 1'b0;
          turn_q   <= 1'b0;
          occ_q    <= '0;
        end
        S_WAIT: begin
          if (tmo_hit) begin
            winner_q <= mark_of(~turn_q);
            state_q  <= S_DONE;
          end else if (xfer) begin
            if (legal) begin
              board_q <= board_q | (BW'(mark_in) << {move_pos, 1'b0});
              side_q  <= move_side;
              row_q   <= 5'(int'(move_pos) / N);
              col_q   <= 5'(int'(move_pos) % N);
              occ_q   <= occ_q + 7'd1;
              dist_q  <= 3'd1;
              back_q  <= 1'b0;
              dir_q   <= 2'd0;
              run_q   <= 4'd1;
              alive_q <= 1'b1;
              hit_q   <= 1'b0;
              state_q <= S_CHECK;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        // Fixed-length scan: every direction/side takes K-1 steps even after a break in the run
        S_CHECK: begin
          if (last_side) begin
            dist_q  <= 3'd1;
            back_q  <= ~back_q;
            alive_q <= 1'b1;
          end else begin
            dist_q  <= dist_q + 3'd1;
            alive_q <= step_ok;
          end
          if (last_side && back_q) begin
            run_q <= 4'd1;
            hit_q <= hit_q | hit_dir;
            dir_q <= dir_q + 2'd1;
            if (dir_q == 2'd3) state_q <= S_EVAL;
          end else begin
            run_q <= run_nx;
          end
        end
        S_EVAL: begin
          if (hit_q) begin
            winner_q <= mark;
            state_q  <= S_DONE;
          end else if (occ_q == 7'(CELLS)) begin
            draw_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            turn_q  <= ~turn_q;
            state_q <= S_WAIT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign board        = board_q;
  assign turn         = turn_q;
  assign illegal_move = illegal_q;
  assign winner       = winner_q;
  assign draw         = draw_q;
  assign game_over    = (state_q == S_DONE);

endmodule

// File: tb/tb_nk_board_game_ctrl.sv
// Directed bench for nk_board_game_ctrl: 3x3/K=3 move table, 5x5/K=4 anti-diagonal game, reset and timeout corners.
module tb_nk_board_game_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // 3x3, K=3 instance
  logic        reset_a, start_a, mv_a, ms_a, ready_a, turn_a, ill_a, draw_a, go_a, tmo_a;
  logic [5:0]  mp_a;
  logic [17:0] board_a;
  logic [1:0]  win_a;

  nk_board_game_ctrl #(.N(3), .K(3), .POS_W(6), .TIMEOUT_CYCLES(255)) dut_a (
    .clock(clock), .reset(reset_a), .start(start_a), .move_valid(mv_a), .move_ready(ready_a),
    .move_side(ms_a), .move_pos(mp_a), .board(board_a), .turn(turn_a), .illegal_move(ill_a),
    .winner(win_a), .draw(draw_a), .game_over(go_a), .timeout(tmo_a));

  // 5x5, K=4 instance
  logic        reset_b, start_b, mv_b, ms_b, ready_b, turn_b, ill_b, draw_b, go_b, tmo_b;
  logic [5:0]  mp_b;
  logic [49:0] board_b;
  logic [1:0]  win_b;

  nk_board_game_ctrl #(.N(5), .K(4), .POS_W(6), .TIMEOUT_CYCLES(255)) dut_b (
    .clock(clock), .reset(reset_b), .start(start_b), .move_valid(mv_b), .move_ready(ready_b),
    .move_side(ms_b), .move_pos(mp_b), .board(board_b), .turn(turn_b), .illegal_move(ill_b),
    .winner(win_b), .draw(draw_b), .game_over(go_b), .timeout(tmo_b));

`ifdef GAME_TIMEOUT_EN
  logic        reset_c, start_c, mv_c, ms_c, ready_c, turn_c, ill_c, draw_c, go_c, tmo_c;
  logic [5:0]  mp_c;
  logic [17:0] board_c;
  logic [1:0]  win_c;

  nk_board_game_ctrl #(.N(3), .K(3), .POS_W(6), .TIMEOUT_CYCLES(10)) dut_c (
    .clock(clock), .reset(reset_c), .start(start_c), .move_valid(mv_c), .move_ready(ready_c),
    .move_side(ms_c), .move_pos(mp_c), .board(board_c), .turn(turn_c), .illegal_move(ill_c),
    .winner(win_c), .draw(draw_c), .game_over(go_c), .timeout(tmo_c));
`endif

  localparam int LAT_A = 8 * (3 - 1) + 2;
  localparam int LAT_B = 8 * (4 - 1) + 2;

  typedef struct {
    bit         new_game;
    bit         side;
    logic [5:0] pos;
    bit         ill;
    bit         go;
    logic [1:0] win;
    bit         drw;
    bit         turn;
  } vec_t;

  vec_t        vt[17];
  logic [17:0] mb;

  function automatic vec_t mk(bit ng, bit s, int p, bit il, bit g, logic [1:0] w, bit d, bit t);
    vec_t v;
    v.new_game = ng; v.side = s; v.pos = 6'(p); v.ill = il;
    v.go = g; v.win = w; v.drw = d; v.turn = t;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offers one move on the negedge; lat counts cycles after the transfer cycle until ready or game_over
  task automatic play_a(input bit side, input logic [5:0] pos, output int lat, output logic il, output logic il2);
    int guard = 0;
    while (!ready_a && guard < 200) begin @(negedge clock); guard++; end
    mv_a = 1'b1; ms_a = side; mp_a = pos;
    @(negedge clock);
    mv_a = 1'b0;
    il  = ill_a;
    lat = 1;
    @(negedge clock);
    il2 = ill_a;
    lat = 2;
    while (!(ready_a || go_a) && lat < 200) begin @(negedge clock); lat++; end
  endtask

  task automatic play_b(input bit side, input logic [5:0] pos, output int lat);
    int guard = 0;
    while (!ready_b && guard < 200) begin @(negedge clock); guard++; end
    mv_b = 1'b1; ms_b = side; mp_b = pos;
    @(negedge clock);
    mv_b = 1'b0;
    lat = 1;
    while (!(ready_b || go_b) && lat < 200) begin @(negedge clock); lat++; end
  endtask

  task automatic new_game_a();
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    mb = '0;
    check("start_ready", ready_a, 1'b1);
    check("start_board", board_a, 18'd0);
    check("start_winner", win_a, 2'b00);
    check("start_draw", draw_a, 1'b0);
    check("start_turn", turn_a, 1'b0);
  endtask

  initial begin
    int         lat;
    logic       il, il2;
    bit         bs[8];
    int         bp[8];

    reset_a = 1'b1; start_a = 1'b0; mv_a = 1'b0; ms_a = 1'b0; mp_a = '0;
    reset_b = 1'b1; start_b = 1'b0; mv_b = 1'b0; ms_b = 1'b0; mp_b = '0;
`ifdef GAME_TIMEOUT_EN
    reset_c = 1'b1; start_c = 1'b0; mv_c = 1'b0; ms_c = 1'b0; mp_c = '0;
`endif
    mb = '0;

    // Row win with illegal attempts interleaved, then a full-board draw
    vt[0]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 1);
    vt[1]  = mk(0, 1, 0, 1, 0, 2'b00, 0, 1);
    vt[2]  = mk(0, 1, 9, 1, 0, 2'b00, 0, 1);
    vt[3]  = mk(0, 0, 3, 1, 0, 2'b00, 0, 1);
    vt[4]  = mk(0, 1, 4, 0, 0, 2'b00, 0, 0);
    vt[5]  = mk(0, 0, 1, 0, 0, 2'b00, 0, 1);
    vt[6]  = mk(0, 1, 8, 0, 0, 2'b00, 0, 0);
    vt[7]  = mk(0, 0, 2, 0, 1, 2'b01, 0, 0);
    vt[8]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 1);
    vt[9]  = mk(0, 1, 1, 0, 0, 2'b00, 0, 0);
    vt[10] = mk(0, 0, 2, 0, 0, 2'b00, 0, 1);
    vt[11] = mk(0, 1, 4, 0, 0, 2'b00, 0, 0);
    vt[12] = mk(0, 0, 3, 0, 0, 2'b00, 0, 1);
    vt[13] = mk(0, 1, 5, 0, 0, 2'b00, 0, 0);
    vt[14] = mk(0, 0, 7, 0, 0, 2'b00, 0, 1);
    vt[15] = mk(0, 1, 6, 0, 0, 2'b00, 0, 0);
    vt[16] = mk(0, 0, 8, 0, 1, 2'b00, 1, 0);

    repeat (3) @(negedge clock);
    reset_a = 1'b0; reset_b = 1'b0;
    @(negedge clock);
    check("rst_board", board_a, 18'd0);
    check("rst_turn", turn_a, 1'b0);
    check("rst_winner", win_a, 2'b00);
    check("rst_draw", draw_a, 1'b0);
    check("rst_game_over", go_a, 1'b0);
    check("rst_ready", ready_a, 1'b0);
    check("rst_illegal", ill_a, 1'b0);
    check("rst_timeout", tmo_a, 1'b0);

    for (int i = 0; i < 17; i++) begin
      if (vt[i].new_game) new_game_a();
      play_a(vt[i].side, vt[i].pos, lat, il, il2);
      if (!vt[i].ill) begin
        mb[2*vt[i].pos +: 2] = vt[i].side ? 2'b10 : 2'b01;
        check($sformatf("v%0d_latency", i), 64'(lat), 64'(LAT_A));
      end
      check($sformatf("v%0d_illegal", i), il, vt[i].ill);
      check($sformatf("v%0d_illegal_off", i), il2, 1'b0);
      check($sformatf("v%0d_board", i), board_a, mb);
      check($sformatf("v%0d_turn", i), turn_a, vt[i].turn);
      check($sformatf("v%0d_game_over", i), go_a, vt[i].go);
      check($sformatf("v%0d_winner", i), win_a, vt[i].win);
      check($sformatf("v%0d_draw", i), draw_a, vt[i].drw);
      if (i == 7) check("row_win_cells", board_a[5:0], 6'b010101);
    end

    // Moves offered in DONE are ignored without an illegal pulse
    mv_a = 1'b1; ms_a = 1'b0; mp_a = 6'd4;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("done_no_illegal", ill_a, 1'b0);
      check("done_hold", go_a, 1'b1);
    end
    mv_a = 1'b0;
    check("done_board_frozen", board_a, mb);
    new_game_a();

    // start while waiting for a move is ignored
    play_a(1'b0, 6'd0, lat, il, il2);
    mb[1:0] = 2'b01;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    @(negedge clock);
    check("start_in_wait_board", board_a, mb);
    check("start_in_wait_turn", turn_a, 1'b1);

    // Reset in the middle of a scan
    mv_a = 1'b1; ms_a = 1'b1; mp_a = 6'd4;
    @(negedge clock);
    mv_a = 1'b0;
    check("mid_check_busy", ready_a, 1'b0);
    repeat (3) @(negedge clock);
    reset_a = 1'b1;
    @(negedge clock);
    reset_a = 1'b0;
    check("midrst_board", board_a, 18'd0);
    check("midrst_turn", turn_a, 1'b0);
    check("midrst_ready", ready_a, 1'b0);
    check("midrst_game_over", go_a, 1'b0);
    check("midrst_winner", win_a, 2'b00);
    repeat (30) @(negedge clock);
    check("midrst_stays_idle", ready_a, 1'b0);
    check("midrst_no_done", go_a, 1'b0);

    // 5x5 K=4: computer completes the anti-diagonal 3,7,11,15
    bs = '{0, 1, 0, 1, 0, 1, 0, 1};
    bp = '{0, 3, 1, 7, 5, 11, 12, 15};
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    check("b_start_ready", ready_b, 1'b1);
    for (int m = 0; m < 8; m++) begin
      play_b(bs[m], 6'(bp[m]), lat);
      check($sformatf("b%0d_latency", m), 64'(lat), 64'(LAT_B));
      check($sformatf("b%0d_game_over", m), go_b, (m == 7) ? 1'b1 : 1'b0);
    end
    check("b_winner", win_b, 2'b10);
    check("b_draw", draw_b, 1'b0);
    check("b_cell15", board_b[31:30], 2'b10);
    check("b_cell12", board_b[25:24], 2'b01);

`ifdef GAME_TIMEOUT_EN
    // No move after start: player forfeits
    reset_c = 1'b0;
    @(negedge clock);
    start_c = 1'b1;
    @(negedge clock);
    start_c = 1'b0;
    lat = 0;
    while (!go_c && lat < 60) begin @(negedge clock); lat++; end
    check("tmo_game_over", go_c, 1'b1);
    check("tmo_winner", win_c, 2'b10);
    check("tmo_flag", tmo_c, 1'b1);
    check("tmo_draw", draw_c, 1'b0);
`else
    check("no_timeout_a", tmo_a, 1'b0);
    check("no_timeout_b", tmo_b, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
